// File: rtl/bitty_uart_tx_slave_if.sv
// Data-RAM-style bus between the core/decoder and the UART transmitter.
// Single-cycle: ce/we/addr/sel/data_i in, combinational data_o back.
interface bitty_uart_tx_slave_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (output ce, we, addr, sel, data_i, input data_o);
  modport slave  (input ce, we, addr, sel, data_i, output data_o);
endinterface

// File: rtl/bitty_uart_tx_slave.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO.
// Registers: TXDATA, STATUS, BAUDDIV, CTRL.
module bitty_uart_tx_slave #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic                        clk,
  input  logic                        rst,
  bitty_uart_tx_slave_if.slave        bus,
  output logic                        txd,
  output logic                        irq
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]     count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     div_q, div_d;
  logic            tx_en_q, tx_en_d, irq_en_q, irq_en_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;

  logic            wr, rd, push, push_ok, pop, full, empty, busy, bit_end;
  logic [1:0]      ra;
  logic [3:0]      cnt4;
  logic [31:0]     rdata;
  logic            unused_bits;

  assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.sel[3:2], bus.data_i[31:16]};

  assign wr      = bus.ce & bus.we;
  assign rd      = bus.ce & ~bus.we;
  assign ra      = bus.addr[3:2];
  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign busy    = (state_q != S_IDLE);
  assign bit_end = (cnt_q >= div_q);
  assign push    = wr & (ra == 2'd0) & bus.sel[0];
  // A push into a full FIFO still fits if the transmitter frees a slot this cycle.
  assign push_ok = push & (~full | pop);

  // Transmit FSM; BAUDDIV is compared live so mid-bit changes apply immediately.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_en_q & ~empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else cnt_d = cnt_q + 16'd1;
      end
      default: begin
        if (bit_end) begin
          cnt_d = '0;
          if (tx_en_q & ~empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rptr_q];
            state_d = S_START;
          end else state_d = S_IDLE;
        end else cnt_d = cnt_q + 16'd1;
      end
    endcase
  end

  // FIFO bookkeeping and register writes.
  always_comb begin
    wptr_d   = wptr_q + AW'(push_ok);
    rptr_d   = rptr_q + AW'(pop);
    count_d  = count_q;
    ovf_d    = ovf_q;
    div_d    = div_q;
    tx_en_d  = tx_en_q;
    irq_en_d = irq_en_q;
    if (push_ok & ~pop)      count_d = count_q + (AW+1)'(1);
    else if (~push_ok & pop) count_d = count_q - (AW+1)'(1);
    if (push & ~push_ok) ovf_d = 1'b1;
    if (wr) begin
      case (ra)
        2'd1: if (bus.sel[0] & bus.data_i[3]) ovf_d = 1'b0;
        2'd2: begin
          if (bus.sel[0]) div_d[7:0]  = bus.data_i[7:0];
          if (bus.sel[1]) div_d[15:8] = bus.data_i[15:8];
        end
        2'd3: if (bus.sel[0]) begin
          tx_en_d  = bus.data_i[0];
          irq_en_d = bus.data_i[1];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      div_q    <= DIV_RESET;
      tx_en_q  <= 1'b0;
      irq_en_q <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      div_q    <= div_d;
      tx_en_q  <= tx_en_d;
      irq_en_q <= irq_en_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
    end
  end

  // Storage needs no reset: emptiness is carried by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= bus.data_i[7:0];
  end

  assign cnt4 = 4'(count_q);

  always_comb begin
    rdata = 32'h0;
    if (rd) begin
      case (ra)
        2'd0:    rdata = 32'h0;
        2'd1:    rdata = {24'h0, cnt4, ovf_q, empty, full, busy};
        2'd2:    rdata = {16'h0, div_q};
        default: rdata = {30'h0, irq_en_q, tx_en_q};
      endcase
    end
  end

  assign bus.data_o = rdata;
  assign txd = (state_q == S_START) ? 1'b0 :
               (state_q == S_DATA)  ? shift_q[0] : 1'b1;
  assign irq = irq_en_q & empty & ~busy;
endmodule
